scm_loader: RTL and testbench
=============================

// Module: scm_loader
// PURPOSE
//  Write-side sequencer for the latch-based scm LUT store (C codebooks x K prototypes).
//  Accepts LUT entries on a valid/ready stream and issues them to the scm write port.
//  Addresses run sequentially from a start address.
//  Enforces the scm write timing: wdata is sampled one edge after we, and the write
//  address is held for the following cycle so the latch captures stable data.
//  Sits between the LUT-fill DMA/host interface and the scm instance.
// PARAMETERS
//  C              32               number of codebooks
//  K              16               prototypes per codebook
//  DataTypeWidth  16               LUT entry width
//  TotalAddrWidth $clog2(C*K)      scm address width; depth D = C*K
// PORTS
//  clk_int      in   1               clock
//  rst_ni       in   1               reset, asynchronous, active-low
//  start_i      in   1               pulse: begin load job (ignored when busy_o=1)
//  abort_i      in   1               stop job after any in-flight write completes
//  start_addr_i in   TotalAddrWidth  first scm address of job
//  len_i        in   TotalAddrWidth+1  entries to write, 1..D (0 = job completes at once)
//  in_valid_i   in   1               entry valid
//  in_data_i    in   DataTypeWidth   entry data
//  in_ready_o   out  1               entry accepted when valid&ready at posedge
//  scm_waddr_o  out  TotalAddrWidth  to scm waddr_a_i
//  scm_wdata_o  out  DataTypeWidth   to scm wdata_a_i
//  scm_we_o     out  1               to scm we_a_i
//  busy_o       out  1               job active
//  done_o       out  1               one-cycle pulse at job end (normal or aborted)
//  count_o      out  TotalAddrWidth+1  entries written in current/last job
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (in_ready_o, scm_we_o, busy_o, done_o, count_o,
//  scm_waddr_o, scm_wdata_o).
//  FSM: IDLE, ACCEPT, ISSUE, SETTLE, DONE. Outputs scm_* and count_o are registered.
//  Transitions:
//  - IDLE: on start_i, latch start_addr_i and len_i; count_o<=0; busy_o<=1.
//    Go to DONE if len_i==0, else ACCEPT.
//  - ACCEPT: in_ready_o=1. On handshake, waddr<=addr, wdata<=in_data_i, we<=1; -> ISSUE.
//  - ISSUE: scm_we_o=1 for exactly one cycle, in_ready_o=0. Next: we<=0, addr/data held;
//    -> SETTLE.
//  - SETTLE: scm_we_o=0, scm_waddr_o/scm_wdata_o unchanged; count_o increments on entry.
//    * If entries remain and no abort: in_ready_o=1. A handshake in SETTLE loads the next
//      entry and goes to ISSUE (back-to-back). No handshake -> ACCEPT.
//    * If no entries remain, or abort is pending: in_ready_o=0; -> DONE.
//  - DONE: done_o=1 for one cycle, busy_o<=0; -> IDLE.
//  Throughput is 1 entry / 2 cycles max; handshake-to-scm_we_o latency is 1 cycle.
//  Address sequencing: addr increments after each accepted entry. It wraps D-1 -> 0
//  (D is not necessarily a power of 2; compare against D-1 explicitly).
//  Abort:
//  - abort_i in ACCEPT (no handshake that cycle): -> DONE next cycle.
//  - abort_i in ISSUE or SETTLE: recorded as pending; the in-flight write finishes its
//    SETTLE cycle, then -> DONE.
//  - abort_i with a simultaneous handshake in ACCEPT: the entry is accepted and
//    written, then the job ends.
//  - abort_i in IDLE or DONE: no effect.
//  start_i while busy_o=1 is ignored. start_i in the DONE cycle is ignored.
//  count_o holds its final value until the next start_i.
//  in_data_i is don't-care when in_valid_i=0. in_valid_i may drop without handshake.
//  Async reset mid-job: immediate return to IDLE with all outputs 0; the scm write in
//  progress is lost.
// STRUCTURE
//  scm_pkg: state enum scm_ld_state_e, function scm_addr_width(C,K),
//  localparam-style depth helper.
//  Single module, no sub-module. The address counter with wrap is inline; a separate
//  counter module is not warranted.
// TESTING
//  - C=4,K=4, start_addr=0, len=16, valid always 1: 16 writes at addr 0..15, in 32 cycles.
//    Each scm_we_o pulse is followed by one cycle with waddr held. done_o at end;
//    count_o=16.
//  - start_addr=14, len=4: waddr sequence 14,15,0,1 (wrap).
//  - Check with C=3 (D=12), start_addr=11, len=2: waddr 11,0.
//  - Random in_valid gaps (50%): data order preserved.
//  - scm_we_o never high on two consecutive cycles.
//  - Readback via scm read port matches every written entry.
//  - abort_i asserted during ISSUE of 3rd entry (len=10): 3rd write completes, count_o=3,
//    done_o pulses, no 4th handshake.
//  - len_i=0 -> done_o two cycles after start_i, scm_we_o never asserted.
//    start_i during busy ignored.
//  - rst_ni low in the SETTLE cycle: all outputs 0 asynchronously.
//    A new job after reset runs normally.

Source files
------------

// File: rtl/scm_pkg.sv
// Shared types and sizing helpers for the scm LUT store and its loader.
package scm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE,
    ST_SETTLE,
    ST_DONE
  } scm_ld_state_e;

  function automatic int scm_depth(input int c, input int k);
    return c * k;
  endfunction

  function automatic int scm_addr_width(input int c, input int k);
    return (c * k > 1) ? $clog2(c * k) : 1;
  endfunction

endpackage

// File: rtl/scm_loader.sv
// Write-side sequencer for the latch-based scm: streams entries to sequential
// addresses, pulsing we for one cycle and holding addr/data for one more.
module scm_loader
  import scm_pkg::*;
#(
  parameter int C              = 32,
  parameter int K              = 16,
  parameter int DataTypeWidth  = 16,
  parameter int TotalAddrWidth = scm_addr_width(C, K)
) (
  input  logic                      clk_int,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [TotalAddrWidth-1:0] start_addr_i,
  input  logic [TotalAddrWidth:0]   len_i,
  input  logic                      in_valid_i,
  input  logic [DataTypeWidth-1:0]  in_data_i,
  output logic                      in_ready_o,
  output logic [TotalAddrWidth-1:0] scm_waddr_o,
  output logic [DataTypeWidth-1:0]  scm_wdata_o,
  output logic                      scm_we_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [TotalAddrWidth:0]   count_o
);

  localparam int D = scm_depth(C, K);
  localparam logic [TotalAddrWidth-1:0] LastAddr = TotalAddrWidth'(D - 1);

  scm_ld_state_e             state_q, state_d;
  logic [TotalAddrWidth-1:0] addr_q;
  logic [TotalAddrWidth:0]   left_q;
  logic                      abort_q;
  logic                      hs;

  assign hs = in_valid_i & in_ready_o;

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_ACCEPT;
      ST_ACCEPT: begin
        in_ready_o = 1'b1;
        if (in_valid_i)   state_d = ST_ISSUE;
        else if (abort_i) state_d = ST_DONE;
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // A fresh abort here still lets the in-flight write settle, but takes no new entry.
      ST_SETTLE: begin
        if (left_q == '0 || abort_q || abort_i) begin
          state_d = ST_DONE;
        end else begin
          in_ready_o = 1'b1;
          state_d    = in_valid_i ? ST_ISSUE : ST_ACCEPT;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      abort_q     <= 1'b0;
      scm_waddr_o <= '0;
      scm_wdata_o <= '0;
      scm_we_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      count_o     <= '0;
    end else begin
      state_q  <= state_d;
      scm_we_o <= hs;
      done_o   <= (state_q == ST_DONE);
      if (state_q == ST_IDLE && start_i) begin
        addr_q  <= start_addr_i;
        left_q  <= len_i;
        count_o <= '0;
        abort_q <= 1'b0;
        busy_o  <= 1'b1;
      end
      if (state_q == ST_DONE) busy_o <= 1'b0;
      // addr/data only move on a handshake, so they stay put through SETTLE
      if (hs) begin
        scm_waddr_o <= addr_q;
        scm_wdata_o <= in_data_i;
        addr_q      <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        left_q      <= left_q - 1'b1;
      end
      if (state_q == ST_ISSUE) count_o <= count_o + 1'b1;
      if (abort_i && (state_q == ST_ISSUE || state_q == ST_SETTLE ||
                      (state_q == ST_ACCEPT && in_valid_i)))
        abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scm_loader.sv
// Random-stimulus bench for scm_loader with an event-level job model and a
// per-cycle compare of the write port, ready, busy, done and count.
module tb_scm_loader;
  localparam int AW = 4;
  localparam int LW = AW + 1;
  localparam int DW = 16;
  localparam int D  = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, scm_we, busy, done;
  logic [AW-1:0] scm_waddr;
  logic [DW-1:0] scm_wdata;
  logic [LW-1:0] count;

  logic start3 = 1'b0, abort3 = 1'b0;
  logic [AW-1:0] start_addr3 = '0;
  logic [LW-1:0] len3 = '0;
  logic in_ready3, we3, busy3, done3;
  logic [AW-1:0] waddr3;
  logic [DW-1:0] wdata3;
  logic [LW-1:0] count3;

  scm_loader #(.C(4), .K(4), .DataTypeWidth(DW)) dut (
    .clk_int(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .start_addr_i(start_addr), .len_i(len), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata),
    .scm_we_o(scm_we), .busy_o(busy), .done_o(done), .count_o(count));

  scm_loader #(.C(3), .K(4), .DataTypeWidth(DW)) dut3 (
    .clk_int(clk), .rst_ni(rst_n), .start_i(start3), .abort_i(abort3),
    .start_addr_i(start_addr3), .len_i(len3), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready3), .scm_waddr_o(waddr3), .scm_wdata_o(wdata3),
    .scm_we_o(we3), .busy_o(busy3), .done_o(done3), .count_o(count3));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // input driver: fresh data every cycle, valid optionally gapped
  bit feed = 0, gap_mode = 0;
  always @(posedge clk) begin
    #1;
    in_valid = feed & (gap_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    in_data  = DW'($urandom);
  end

  // job model: a job's end is fixed by its last handshake or by when abort arrives
  int cyc = 0, done_at = -1, last_hs = -100, m_left = 0, m_n = 0, m_addr = 0;
  bit m_busy = 0, m_abort = 0;
  bit prev_hs = 0, prev_we = 0;
  int p_addr = 0, pw_addr = 0;
  logic [DW-1:0] p_data = '0, pw_data = '0;
  logic [DW-1:0] exp_mem [D];
  logic [DW-1:0] scm_mem [D];
  bit exp_wr [D];

  always @(negedge clk) begin : cmp_p
    bit h, er;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_abort = 0; m_n = 0; m_left = 0; done_at = -1; last_hs = -100;
      prev_hs = 0; prev_we = 0;
    end else begin
      if (m_busy && cyc == done_at) m_busy = 0;
      h  = in_valid && in_ready;
      er = m_busy && m_left > 0 && !m_abort && cyc != last_hs + 1 &&
           !(abort && cyc == last_hs + 2);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(cyc == done_at));
      chk("ready", 32'(in_ready), 32'(er));
      chk("we", 32'(scm_we), 32'(prev_hs));
      if (prev_hs) begin
        chk("waddr", 32'(scm_waddr), 32'(p_addr));
        chk("wdata", 32'(scm_wdata), 32'(p_data));
      end
      if (prev_we) begin
        chk("waddr_hold", 32'(scm_waddr), 32'(pw_addr));
        chk("wdata_hold", 32'(scm_wdata), 32'(pw_data));
        scm_mem[int'(scm_waddr)] = scm_wdata;
      end
      if (!m_busy) chk("count", 32'(count), 32'(m_n));
      if (h) begin
        exp_mem[m_addr] = in_data;
        exp_wr[m_addr]  = 1;
        p_addr = m_addr;
        p_data = in_data;
        m_addr = (m_addr + 1) % D;
        m_left--;
        m_n++;
        last_hs = cyc;
        if (m_left == 0) done_at = cyc + 4;
      end
      if (m_busy && abort && !m_abort && m_left > 0) begin
        m_abort = 1;
        done_at = (h || cyc <= last_hs + 2) ? last_hs + 4 : cyc + 2;
      end
      if (!m_busy && start) begin
        m_busy = 1; m_abort = 0; m_n = 0; last_hs = -100;
        m_addr = int'(start_addr);
        m_left = int'(len);
        done_at = (len == '0) ? cyc + 2 : -1;
      end
      prev_hs = h;
      prev_we = scm_we;
      pw_addr = int'(scm_waddr);
      pw_data = scm_wdata;
    end
  end

  int wlog[$];

  task automatic run_job(input int sa, input int ln, input bit gaps, input int abort_n,
                         input int restart_at, input bit hold_start,
                         output int done_c, output int wn);
    done_c = -1; wn = 0; wlog.delete();
    gap_mode = gaps; feed = 1;
    @(posedge clk); #1;
    start_addr = AW'(sa); len = LW'(ln); start = 1;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(posedge clk); #1;
      start = 0; abort = 0;
      if (c == 0 && hold_start) start = 1;
      if (c == restart_at) begin start = 1; start_addr = AW'($urandom); len = LW'(3); end
      if (scm_we) begin
        wn++;
        wlog.push_back(int'(scm_waddr));
        if (wn == abort_n) abort = 1;
      end
      if (done) done_c = c;
    end
    start = 0; abort = 0; feed = 0;
    chk("job_done_seen", 32'(done_c >= 0), 1);
  endtask

  logic [DW-1:0] hs3_data[$];
  always @(negedge clk) if (rst_n && in_valid && in_ready3) hs3_data.push_back(in_data);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, wn, sa, ln;
    int a3[$];
    for (int i = 0; i < D; i++) begin exp_wr[i] = 0; exp_mem[i] = '0; scm_mem[i] = '0; end
    #12;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(scm_we), 0);
    chk("rst_waddr", 32'(scm_waddr), 0);
    chk("rst_wdata", 32'(scm_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    @(posedge clk); #3 rst_n = 1;
    repeat (2) @(posedge clk);

    // full fill at full rate, with an ignored start mid-job
    run_job(0, 16, 0, -1, 5, 0, dc, wn);
    chk("full_writes", wn, 16);
    chk("full_done_cycle", dc, 34);
    chk("full_count", 32'(count), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) chk("full_addr", wlog[i], i);

    // wrap 15 -> 0
    run_job(14, 4, 0, -1, -1, 0, dc, wn);
    chk("wrap_writes", wn, 4);
    if (wlog.size() == 4) begin
      chk("wrap_a0", wlog[0], 14); chk("wrap_a1", wlog[1], 15);
      chk("wrap_a2", wlog[2], 0);  chk("wrap_a3", wlog[3], 1);
    end

    // abort in the ISSUE cycle of the 3rd entry
    run_job(2, 10, 0, 3, -1, 0, dc, wn);
    chk("abort_writes", wn, 3);
    chk("abort_count", 32'(count), 3);

    // abort while idle, then a zero-length job with start held into its DONE cycle
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    run_job(5, 0, 0, -1, -1, 1, dc, wn);
    chk("len0_done_cycle", dc, 1);
    chk("len0_writes", wn, 0);
    chk("len0_count", 32'(count), 0);

    // random jobs with 50% valid gaps
    repeat (6) begin
      sa = int'($urandom_range(0, D - 1));
      ln = int'($urandom_range(1, D));
      run_job(sa, ln, 1, -1, -1, 0, dc, wn);
      chk("rnd_writes", wn, ln);
      chk("rnd_count", 32'(count), 32'(ln));
    end

    repeat (2) @(posedge clk);
    for (int a = 0; a < D; a++)
      if (exp_wr[a]) chk("readback", 32'(scm_mem[a]), 32'(exp_mem[a]));

    // D=12 instance: 11 wraps to 0
    hs3_data.delete();
    feed = 1; gap_mode = 0;
    @(posedge clk); #1 start_addr3 = AW'(11); len3 = LW'(2); start3 = 1;
    @(posedge clk); #1 start3 = 0;
    for (int c = 0; c < 30 && !done3; c++) begin
      @(posedge clk); #1;
      if (we3) begin
        a3.push_back(int'(waddr3));
        if (hs3_data.size() > 0) chk("d12_wdata", 32'(wdata3), 32'(hs3_data.pop_front()));
        else chk("d12_hs_before_we", 0, 1);
      end
    end
    feed = 0;
    chk("d12_done", 32'(done3), 1);
    chk("d12_writes", a3.size(), 2);
    if (a3.size() == 2) begin chk("d12_a0", a3[0], 11); chk("d12_a1", a3[1], 0); end
    chk("d12_count", 32'(count3), 2);
    chk("d12_busy", 32'(busy3), 0);
    chk("d12_ready", 32'(in_ready3), 0);

    // async reset in the SETTLE cycle of a running job
    feed = 1; gap_mode = 0;
    @(posedge clk); #1 start_addr = AW'(4); len = LW'(8); start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < 20 && !scm_we; c++) begin @(posedge clk); #1; end
    chk("rst_job_we_seen", 32'(scm_we), 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_we", 32'(scm_we), 0);
    chk("arst_waddr", 32'(scm_waddr), 0);
    chk("arst_wdata", 32'(scm_wdata), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_count", 32'(count), 0);
    feed = 0;
    @(posedge clk); #3 rst_n = 1;
    repeat (2) @(posedge clk);
    run_job(3, 5, 1, -1, -1, 0, dc, wn);
    chk("post_rst_writes", wn, 5);
    chk("post_rst_count", 32'(count), 5);
    if (wlog.size() == 5) chk("post_rst_a4", wlog[4], 7);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
